// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for the variable-rate CIC decimator: applies range-checked rate requests
// at an output boundary, blanks the settling transient and applies saturating power-of-two gain.
//
// state    | meaning
// IDLE     | accepting rate requests, output stream passes
// WAIT_BND | request latched, waiting for an output sample (or timeout) to apply it
// APPLY    | one-cycle rate pulse to the CIC, new gain shift takes effect
// SETTLE   | blanking CIC_N+SETTLE_XTRA transient output samples
module cic_rate_ctrl #(
    parameter int RATE_DW     = 16,
    parameter int OUT_DW      = 32,
    parameter int CIC_N       = 7,
    parameter int CIC_R_MAX   = 10,
    parameter int SETTLE_XTRA = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
    input  logic               s_axis_cfg_tvalid,
    output logic               s_axis_cfg_tready,
    output logic [RATE_DW-1:0] cic_rate_tdata,
    output logic               cic_rate_tvalid,
    input  logic [OUT_DW-1:0]  cic_out_tdata,
    input  logic               cic_out_tvalid,
    output logic [OUT_DW-1:0]  m_axis_out_tdata,
    output logic               m_axis_out_tvalid,
    output logic               busy,
    output logic               err_range,
    output logic [7:0]         gain_shift
);

    localparam int LOG_MAX    = $clog2(CIC_R_MAX);
    localparam int WAIT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int SETTLE_CNT = CIC_N + SETTLE_XTRA;
    localparam int SET_W      = $clog2(SETTLE_CNT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        APPLY    = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic               cfg_legal;
    logic               cfg_hs;
    logic               blank;
    logic [RATE_DW-1:0] pend_rate;
    logic [7:0]         pend_shift;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [SET_W-1:0]   settle_cnt;

    // ceil(log2(r)) as a priority encode of r-1; r=1 gives 0
    function automatic logic [7:0] ceil_log2(input logic [RATE_DW-1:0] r);
        logic [RATE_DW-1:0] m;
        logic [7:0]         res;
        m   = r - 1'b1;
        res = '0;
        for (int i = 0; i < RATE_DW; i++) begin
            if (m[i]) res = 8'(i + 1);
        end
        return res;
    endfunction

    function automatic logic [OUT_DW-1:0] sat_shl(input logic [OUT_DW-1:0] x,
                                                  input logic [7:0]        sh);
        logic [2*OUT_DW-1:0] wide;
        logic [OUT_DW-1:0]   sat_val;
        sat_val = x[OUT_DW-1] ? {1'b1, {(OUT_DW-1){1'b0}}} : {1'b0, {(OUT_DW-1){1'b1}}};
        if (x == '0) return '0;
        if (int'(sh) >= OUT_DW) return sat_val;
        wide = {{OUT_DW{x[OUT_DW-1]}}, x} << sh;
        if (wide[2*OUT_DW-1:OUT_DW-1] == {(OUT_DW+1){x[OUT_DW-1]}}) return wide[OUT_DW-1:0];
        return sat_val;
    endfunction

    // Reset asserts immediately but releases synchronously to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign cfg_legal = (s_axis_cfg_tdata != '0) &&
                       (s_axis_cfg_tdata <= RATE_DW'(CIC_R_MAX));
    assign cfg_hs    = s_axis_cfg_tvalid && s_axis_cfg_tready;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        s_axis_cfg_tready = 1'b0;
        cic_rate_tvalid   = 1'b0;
        busy              = 1'b1;
        blank             = 1'b0;
        case (state)
            IDLE: begin
                s_axis_cfg_tready = 1'b1;
                busy              = 1'b0;
                if (s_axis_cfg_tvalid && cfg_legal) state_nxt = WAIT_BND;
            end
            WAIT_BND: begin
                if (cic_out_tvalid || wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) state_nxt = APPLY;
            end
            APPLY: begin
                cic_rate_tvalid = 1'b1;
                blank           = 1'b1;
                state_nxt       = SETTLE;
            end
            SETTLE: begin
                blank = 1'b1;
                if (cic_out_tvalid && settle_cnt == SET_W'(SETTLE_CNT - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            err_range      <= 1'b0;
            pend_rate      <= RATE_DW'(CIC_R_MAX);
            pend_shift     <= '0;
            cic_rate_tdata <= RATE_DW'(CIC_R_MAX);
            gain_shift     <= '0;
            wait_cnt       <= '0;
            settle_cnt     <= '0;
        end else begin
            err_range <= cfg_hs && !cfg_legal;
            if (cfg_hs && cfg_legal) begin
                pend_rate  <= s_axis_cfg_tdata;
                pend_shift <= 8'(CIC_N * (LOG_MAX - int'(ceil_log2(s_axis_cfg_tdata))));
            end
            if (state == WAIT_BND) wait_cnt <= wait_cnt + 1'b1;
            else                   wait_cnt <= '0;
            if (state != SETTLE)      settle_cnt <= '0;
            else if (cic_out_tvalid)  settle_cnt <= settle_cnt + 1'b1;
            // Rate word and gain switch on the same edge that raises the rate pulse
            if (state == WAIT_BND && state_nxt == APPLY) begin
                cic_rate_tdata <= pend_rate;
                gain_shift     <= pend_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
        end else begin
            m_axis_out_tvalid <= cic_out_tvalid && !blank;
            if (cic_out_tvalid) m_axis_out_tdata <= sat_shl(cic_out_tdata, gain_shift);
        end
    end

endmodule
